// File: rtl/vga_key_char_feeder.sv
// ---------------------------------------------------------------------------
// VgaKeyCharFeeder (module vga_key_char_feeder)
//
// Upstream feeder for the VGA text controller. A raw active-low pushbutton is
// synchronised and debounced. Each debounced press captures the switch
// character into a small first-word-fall-through FIFO. The FIFO head is
// offered to the controller over a valid/ready handshake, so presses made
// while the controller is busy are buffered rather than lost.
//
// Parameters
//   DATA_W    character width in bits
//   DEPTH     FIFO entries (any value >= 1, not restricted to powers of two)
//   DEB_BITS  debounce counter width; a new key level must stay stable for
//             2**DEB_BITS cycles before it is accepted
//
// Ports
//   iCLK    in   system clock (VGA pixel clock domain)
//   iRST_n  in   asynchronous active-low reset
//   iKEY_n  in   raw pushbutton, active low, asynchronous to iCLK
//   iCHAR   in   switch character, sampled on the debounced press edge
//   oCHAR   out  FIFO head character (meaningful while oVALID=1)
//   oVALID  out  FIFO non-empty
//   iREADY  in   consumer takes oCHAR this cycle
//   oFULL   out  FIFO holds DEPTH entries
//   oEMPTY  out  FIFO holds no entries
//   oCOUNT  out  current occupancy
//   oDROP   out  one-cycle pulse: a press was lost because the FIFO was full
// ---------------------------------------------------------------------------
module vga_key_char_feeder #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 6,
    parameter int DEB_BITS = 15
) (
    input  logic                         iCLK,
    input  logic                         iRST_n,
    input  logic                         iKEY_n,
    input  logic [DATA_W-1:0]            iCHAR,
    output logic [DATA_W-1:0]            oCHAR,
    output logic                         oVALID,
    input  logic                         iREADY,
    output logic                         oFULL,
    output logic                         oEMPTY,
    output logic [$clog2(DEPTH+1)-1:0]   oCOUNT,
    output logic                         oDROP
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    // A one-entry FIFO still needs a one-bit pointer to keep widths legal.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DEB_BITS-1:0] DEB_MAX  = '1;
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Key path state
    // ------------------------------------------------------------------
    logic                sync1_q;
    logic                sync2_q;
    logic                deb_q;
    logic                deb_d;
    logic [DEB_BITS-1:0] debCnt_q;
    logic [DEB_BITS-1:0] debCnt_d;
    logic                pushReq;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wrPtr_q;
    logic [PTR_W-1:0]    wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q;
    logic [PTR_W-1:0]    rdPtr_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                full_q;
    logic                full_d;
    logic                empty_q;
    logic                empty_d;
    logic                drop_q;
    logic                drop_d;
    logic                pop;
    logic                push;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous key. Both flops reset to
    // the released level so reset release never looks like a press.
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= iKEY_n;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the counter runs only while the synchronised level differs
    // from the accepted level, and any return to the accepted level restarts
    // it. When it saturates the new level is accepted. Only the 1->0
    // transition (a press) raises pushReq, in the same cycle deb flips.
    // ------------------------------------------------------------------
    always_comb begin
        deb_d    = deb_q;
        debCnt_d = debCnt_q;
        pushReq  = 1'b0;
        if (sync2_q == deb_q) begin
            debCnt_d = '0;
        end else if (debCnt_q != DEB_MAX) begin
            debCnt_d = debCnt_q + DEB_BITS'(1);
        end else begin
            deb_d    = sync2_q;
            debCnt_d = '0;
            pushReq  = deb_q;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            deb_q    <= 1'b1;
            debCnt_q <= '0;
        end else begin
            deb_q    <= deb_d;
            debCnt_q <= debCnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control. A pop frees a slot in the same cycle, so a press that
    // arrives while full is still accepted when the consumer is popping.
    // Occupancy and the full/empty flags are all derived from the same
    // next count so they can never disagree.
    // ------------------------------------------------------------------
    always_comb begin
        pop     = ~empty_q & iREADY;
        push    = pushReq & (~full_q | pop);
        drop_d  = pushReq & full_q & ~pop;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;

        if (push) begin
            wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    // ------------------------------------------------------------------
    // FIFO registers. Storage is cleared on reset so oCHAR reads zero
    // straight out of reset and no stale character survives a reset.
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= iCHAR;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            drop_q  <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: first-word fall-through, the head is always visible.
    // ------------------------------------------------------------------
    assign oCHAR  = mem_q[rdPtr_q];
    assign oVALID = ~empty_q;
    assign oFULL  = full_q;
    assign oEMPTY = empty_q;
    assign oCOUNT = count_q;
    assign oDROP  = drop_q;

endmodule
